score_display_mux: RTL and testbench

Parametrised multi-player score driver for the board's multiplexed common-anode 7-segment display. It takes binary scores for every player and converts them to BCD with one shared sequential double-dabble converter. It then time-multiplexes all digits onto a single segment bus, with optional leading-zero blanking, overflow saturation and per-player blinking for win indication. It sits between the game-state logic (score registers) and the top-level seg/an pins.

---
 rtl/score_display_mux_pkg.sv | 27 ++
 rtl/score_display_mux_bin2bcd_seq.sv | 76 +++++++
 rtl/score_display_mux.sv | 191 +++++++++++++++++++
 tb/tb_score_display_mux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_mux_pkg.sv
// Shared constants and types for the multiplexed score display.
package score_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Nibbles above 9 never reach the decoder; they map to blank for safety.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    if (v > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[v];
  endfunction

endpackage

// File: rtl/score_display_mux_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, start counts as the
// first shift. Scores that do not fit in DIGITS decimal digits saturate to 9s.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int SCORE_W = 6,
  parameter int DIGITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sat,
  output logic                  busy,
  output logic                  last,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  logic [SCORE_W-1:0] bin_sr;
  logic [BW-1:0]      bcd_sr;
  logic [BW-1:0]      bcd_base;
  logic [BW-1:0]      bcd_adj;
  logic [CW-1:0]      cnt;
  logic               shift_in;

  // A fresh start shifts from an all-zero BCD accumulator.
  assign bcd_base = start ? '0 : bcd_sr;
  assign shift_in = start ? bin[SCORE_W-1] : bin_sr[SCORE_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_base[gi*4 +: 4] >= 4'd5) ?
                                  bcd_base[gi*4 +: 4] + 4'd3 : bcd_base[gi*4 +: 4];
    end
  endgenerate

  // High on the edge that performs the final shift.
  assign last = busy ? (cnt == CW'(SCORE_W - 1)) : (start && (SCORE_W == 1));
  assign bcd  = sat ? {DIGITS{4'd9}} : bcd_sr;

  // Shift/add-3 datapath with its own bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_sr <= bin << 1;
        bcd_sr <= {bcd_adj[BW-2:0], shift_in};
        cnt    <= CW'(1);
        sat    <= (32'(bin) >= pow10(DIGITS));
        busy   <= (SCORE_W > 1);
        done   <= (SCORE_W == 1);
      end else if (busy) begin
        bin_sr <= bin_sr << 1;
        bcd_sr <= {bcd_adj[BW-2:0], shift_in};
        cnt    <= cnt + 1'b1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/score_display_mux.sv
// Multi-player score display driver: shared BCD converter sequenced per
// player, atomic commit to display registers, digit scan, blink and decode.
module score_display_mux
  import score_disp_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PLAYERS*SCORE_W-1:0]   score,
  input  logic                             load,
  input  logic                             blank_lz,
  input  logic [NUM_PLAYERS-1:0]           blink_en,
  output logic [6:0]                       seg,
  output logic [NUM_PLAYERS*DIGITS-1:0]    an,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_PLAYERS-1:0]           ovf
);

  localparam int ND  = NUM_PLAYERS * DIGITS;
  localparam int BW  = 4 * DIGITS;
  localparam int PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int IW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int RW  = $clog2(REFRESH_DIV);
  localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                         state;
  logic [NUM_PLAYERS*SCORE_W-1:0] snap;
  logic [PW-1:0]                  player;
  logic [PW-1:0]                  cap_idx;
  logic                           pending;
  logic [BW-1:0]                  res_buf  [NUM_PLAYERS];
  logic [BW-1:0]                  res_full [NUM_PLAYERS];
  logic [BW-1:0]                  disp     [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]         sat_buf;
  logic [NUM_PLAYERS-1:0]         sat_full;

  logic                           conv_start;
  logic [BW-1:0]                  conv_bcd;
  logic                           conv_sat;
  logic                           conv_busy;
  logic                           conv_last;
  logic                           conv_done;

  logic [RW-1:0]                  rcnt;
  logic [IW-1:0]                  idx;
  logic [BKW-1:0]                 bcnt;
  logic                           phase;
  logic [6:0]                     digit_seg  [ND];
  logic [ND-1:0]                  digit_hide;
  logic [6:0]                     slot_seg;
  logic [ND-1:0]                  slot_an;

  // The converter is idle in CONV exactly when the next player must start.
  assign conv_start = (state == CONV) && !conv_busy;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (snap[player*SCORE_W +: SCORE_W]),
    .bcd   (conv_bcd),
    .sat   (conv_sat),
    .busy  (conv_busy),
    .last  (conv_last),
    .done  (conv_done)
  );

  genvar gi, gj;
  generate
    // The last player's result is still in the converter at commit time.
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_merge
      assign res_full[gi] = (conv_done && cap_idx == PW'(gi)) ? conv_bcd : res_buf[gi];
      assign sat_full[gi] = (conv_done && cap_idx == PW'(gi)) ? conv_sat : sat_buf[gi];
    end

    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      for (gj = 0; gj < DIGITS; gj++) begin : g_digit
        logic       blank;
        assign blank = blank_lz && (gj > 0) && (disp[gi][BW-1:gj*4] == '0);
        assign digit_seg[gi*DIGITS+gj]  = blank ? SEG_BLANK : seg_decode(disp[gi][gj*4 +: 4]);
        assign digit_hide[gi*DIGITS+gj] = blink_en[gi] && phase;
      end
    end
  endgenerate

  // Conversion sequencing, result capture and atomic commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      player  <= '0;
      cap_idx <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= '0;
      sat_buf <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        res_buf[p] <= '0;
        disp[p]    <= '0;
      end
    end else begin
      done <= 1'b0;
      if (conv_done) begin
        res_buf[cap_idx] <= conv_bcd;
        sat_buf[cap_idx] <= conv_sat;
      end
      case (state)
        IDLE: begin
          if (load) begin
            snap   <= score;
            player <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          if (load) pending <= 1'b1;
          if (conv_last) begin
            cap_idx <= player;
            if (player == PW'(NUM_PLAYERS - 1)) state <= COMMIT;
            else player <= player + 1'b1;
          end
        end
        COMMIT: begin
          for (int p = 0; p < NUM_PLAYERS; p++) disp[p] <= res_full[p];
          ovf     <= sat_full;
          done    <= 1'b1;
          pending <= 1'b0;
          if (pending || load) begin
            snap   <= score;
            player <= '0;
            state  <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Selected slot: anode one-hot low unless the owning player is blinked off.
  always_comb begin
    slot_seg = digit_seg[idx];
    slot_an  = ~(ND'(1) << idx);
    if (digit_hide[idx]) slot_an = '1;
  end

  // Refresh divider, scan index, blink phase, and registered seg/an pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt  <= '0;
      idx   <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      seg   <= SEG_BLANK;
      an    <= '1;
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        if (idx == IW'(ND - 1)) begin
          idx <= '0;
          if (bcnt == BKW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      seg <= slot_seg;
      an  <= slot_an;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Randomized bench for score_display_mux with an event-level reference model
// and a done-driven scoreboard.
module tb_score_display_mux;

  localparam int NP  = 2;
  localparam int W   = 7;
  localparam int D   = 2;
  localparam int RD  = 4;
  localparam int BD  = 1;
  localparam int ND  = NP * D;
  localparam int LAT = NP * W + 1;
  localparam int MAXV = 99;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*W-1:0] score = '0;
  logic            load = 1'b0;
  logic            blank_lz = 1'b0;
  logic [NP-1:0]   blink_en = '0;
  logic [6:0]      seg;
  logic [ND-1:0]   an;
  logic            busy;
  logic            done;
  logic [NP-1:0]   ovf;

  always #5 clk = ~clk;

  score_display_mux #(
    .NUM_PLAYERS (NP),
    .SCORE_W     (W),
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .score    (score),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  int checks = 0;
  int passes = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  typedef struct {
    int              due;
    logic [NP*W-1:0] snap;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  bit   m_busy = 1'b0;
  bit   m_pend = 1'b0;
  int   m_end = 0;
  int   disp_val [NP];

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  end

  // Reference: one conversion takes LAT cycles; loads while busy merge into a
  // single restart that samples the score at the end of the current one.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      sb.delete();
    end else if (!m_busy) begin
      if (load) begin
        m_busy = 1'b1;
        m_end  = cyc + LAT;
        sb.push_back('{due: cyc + LAT + 1, snap: score});
      end
    end else if (cyc == m_end) begin
      if (m_pend || load) begin
        m_end  = cyc + LAT;
        m_pend = 1'b0;
        sb.push_back('{due: cyc + LAT + 1, snap: score});
      end else begin
        m_busy = 1'b0;
      end
    end else if (load) begin
      m_pend = 1'b1;
    end
    cyc++;
  end

  // Monitor: busy tracking and done-triggered scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    int   v;
    int   eovf;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) disp_val[p] = 0;
    end else begin
      chk("busy", int'(busy), int'(m_busy));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          eovf = 0;
          for (int p = 0; p < NP; p++) begin
            v = int'(e.snap[p*W +: W]);
            if (v > MAXV) eovf |= (1 << p);
            disp_val[p] = (v > MAXV) ? MAXV : v;
          end
          chk("ovf", int'(ovf), eovf);
        end
      end
    end
  end

  function automatic logic [6:0] exp_seg(int p, int d);
    int v, pw;
    v  = disp_val[p];
    pw = 10 ** d;
    if (blank_lz && d > 0 && v < pw) return 7'b1111111;
    return seg_tab[(v / pw) % 10];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("busy_timeout", int'(busy), 0);
  endtask

  // One full scan frame once the new display has propagated to the pins.
  task automatic frame_check();
    int zeros, slot;
    repeat (2 * RD + 2) @(negedge clk);
    for (int c = 0; c < ND * RD; c++) begin
      @(negedge clk);
      zeros = 0;
      slot  = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) begin zeros++; slot = i; end
      chk("an_onehot", zeros, 1);
      chk($sformatf("seg_slot%0d", slot), int'(seg), int'(exp_seg(slot / D, slot % D)));
    end
  endtask

  task automatic do_load(int s0, int s1, bit blz);
    @(negedge clk);
    score    = {W'(s1), W'(s0)};
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    frame_check();
    $display("load p0=%0d p1=%0d blank_lz=%0d", s0, s1, blz);
  endtask

  task automatic b2b_load(int a0, int a1, int b0, int b1, int off);
    @(negedge clk);
    score = {W'(a1), W'(a0)};
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (off - 1) @(negedge clk);
    score = {W'(b1), W'(b0)};
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    frame_check();
    $display("b2b first=%0d/%0d second=%0d/%0d offset=%0d", a0, a1, b0, b1, off);
  endtask

  task automatic blink_check(logic [NP-1:0] be, int exp0, int exp1);
    int c0 = 0, c1 = 0;
    blink_en = be;
    repeat (8 * ND * RD) @(negedge clk);
    for (int c = 0; c < 8 * ND * RD; c++) begin
      @(negedge clk);
      if (an[1:0] != 2'b11) c0++;
      if (an[3:2] != 2'b11) c1++;
    end
    chk("blink_p0_cycles", c0, exp0);
    chk("blink_p1_cycles", c1, exp1);
    blink_en = '0;
    $display("blink_en=%b p0_on=%0d p1_on=%0d", be, c0, c1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", int'(seg), 7'h7f);
    chk("rst_an", int'(an), 4'hf);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    $display("reset outputs checked");
    rst_n = 1'b1;

    do_load(0, 0, 1'b1);
    do_load(42, 7, 1'b0);
    do_load(127, 5, 1'b1);
    do_load(5, 100, 1'b0);
    do_load(99, 0, 1'b1);
    do_load(9, 10, 1'b1);
    for (int t = 0; t < 8; t++)
      do_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)));

    b2b_load(11, 22, 33, 44, 5);
    b2b_load(120, 3, 8, 101, 14);
    b2b_load(1, 2, 60, 70, LAT);
    b2b_load(int'($urandom_range(0, 127)), 4, int'($urandom_range(0, 127)), 55,
             int'($urandom_range(1, LAT)));

    blink_check(2'b01, 32, 64);
    blink_check(2'b10, 64, 32);

    // Reset in the middle of a conversion discards it entirely.
    blank_lz = 1'b0;
    @(negedge clk);
    score = {W'(77), W'(88)};
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_an", int'(an), 4'hf);
    chk("midrst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3 * LAT) @(negedge clk);
    frame_check();
    $display("mid-conversion reset checked");

    do_load(63, 64, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
